// File: rtl/pipe_id_decoder.sv
// ID-stage main decoder with a registered ID/EX control slot, load-use hazard detection
// and a small bubble-insertion FSM for multi-cycle load-use stalls.
module pipe_id_decoder #(
  parameter int unsigned OP_W         = 6,
  parameter int unsigned ALUOP_W      = 3,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned LU_STALL_CYC = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               instr_valid_i,
  input  logic [31:0]        instr_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               valid_o,
  output logic               RegWrite_o,
  output logic [ALUOP_W-1:0] ALU_op_o,
  output logic               ALUSrc_o,
  output logic               RegDst_o,
  output logic               Branch_o,
  output logic               BranchType_o,
  output logic               Jump_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               MemtoReg_o,
  output logic [REG_W-1:0]   wr_reg_o,
  output logic               hazard_stall_o,
  output logic               illegal_o
);

  localparam logic [OP_W-1:0] OpR    = OP_W'('h00);
  localparam logic [OP_W-1:0] OpJ    = OP_W'('h02);
  localparam logic [OP_W-1:0] OpBeq  = OP_W'('h04);
  localparam logic [OP_W-1:0] OpBne  = OP_W'('h05);
  localparam logic [OP_W-1:0] OpAddi = OP_W'('h08);
  localparam logic [OP_W-1:0] OpSlti = OP_W'('h0A);
  localparam logic [OP_W-1:0] OpLw   = OP_W'('h23);
  localparam logic [OP_W-1:0] OpSw   = OP_W'('h2B);

  localparam logic [0:0] StRun     = 1'b0;
  localparam logic [0:0] StLuStall = 1'b1;

  typedef struct packed {
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_dst;
    logic               branch;
    logic               branch_type;
    logic               jump;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic [REG_W-1:0]   wr_reg;
  } ctl_t;

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rs, rt, rd;
  ctl_t             dec, ctl_d, ctl_q;
  logic             dec_legal, use_rs, use_rt;
  logic             valid_d, valid_q, illegal_d, illegal_q;
  logic [0:0]       state_d, state_q;
  logic [1:0]       cnt_d, cnt_q;
  logic             hazard, hazard_run;

  assign op = instr_i[31 -: OP_W];
  assign rs = instr_i[25 -: REG_W];
  assign rt = instr_i[20 -: REG_W];
  assign rd = instr_i[15 -: REG_W];

  always_comb begin
    dec       = '0;
    dec_legal = 1'b1;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    unique case (op)
      OpR: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        dec.alu_op    = ALUOP_W'(2);
        use_rs        = 1'b1;
        use_rt        = 1'b1;
      end
      OpAddi, OpSlti: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = (op == OpAddi) ? ALUOP_W'(3) : ALUOP_W'(4);
        use_rs        = 1'b1;
      end
      OpLw: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        use_rs         = 1'b1;
      end
      OpSw: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
      end
      OpBeq, OpBne: begin
        dec.branch      = 1'b1;
        dec.branch_type = (op == OpBne);
        dec.alu_op      = ALUOP_W'(1);
        use_rs          = 1'b1;
        use_rt          = 1'b1;
      end
      OpJ:     dec.jump  = 1'b1;
      default: dec_legal = 1'b0;
    endcase
    dec.wr_reg = dec.reg_dst ? rd : rt;
  end

  // Only a valid load in ID/EX with a non-zero destination can create a load-use hazard.
  assign hazard = valid_q & ctl_q.mem_read & instr_valid_i & (ctl_q.wr_reg != '0) &
                  ((use_rs & (rs == ctl_q.wr_reg)) | (use_rt & (rt == ctl_q.wr_reg)));
  assign hazard_run     = (state_q == StRun) & hazard;
  assign hazard_stall_o = hazard_run | (state_q == StLuStall);

  always_comb begin
    ctl_d     = ctl_q;
    valid_d   = valid_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    if (flush_i) begin
      ctl_d   = '0;
      valid_d = 1'b0;
      state_d = StRun;
      cnt_d   = '0;
    end else if (stall_i) begin
      // Hold everything; illegal_o stays a single-cycle pulse.
    end else if (state_q == StLuStall) begin
      ctl_d   = '0;
      valid_d = 1'b0;
      cnt_d   = cnt_q - 2'd1;
      if (cnt_q == 2'd1) state_d = StRun;
    end else if (hazard_run) begin
      ctl_d   = '0;
      valid_d = 1'b0;
      if (LU_STALL_CYC > 1) begin
        state_d = StLuStall;
        cnt_d   = 2'(LU_STALL_CYC - 1);
      end
    end else if (instr_valid_i && dec_legal) begin
      ctl_d   = dec;
      valid_d = 1'b1;
    end else begin
      ctl_d     = '0;
      valid_d   = 1'b0;
      illegal_d = instr_valid_i & ~dec_legal;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctl_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      state_q   <= StRun;
      cnt_q     <= '0;
    end else begin
      ctl_q     <= ctl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign RegWrite_o   = ctl_q.reg_write;
  assign ALU_op_o     = ctl_q.alu_op;
  assign ALUSrc_o     = ctl_q.alu_src;
  assign RegDst_o     = ctl_q.reg_dst;
  assign Branch_o     = ctl_q.branch;
  assign BranchType_o = ctl_q.branch_type;
  assign Jump_o       = ctl_q.jump;
  assign MemRead_o    = ctl_q.mem_read;
  assign MemWrite_o   = ctl_q.mem_write;
  assign MemtoReg_o   = ctl_q.mem_to_reg;
  assign wr_reg_o     = ctl_q.wr_reg;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_pipe_id_decoder.sv
// Directed bench for pipe_id_decoder: one instance with 1 load-use bubble, one with 3.
module tb_pipe_id_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v1 = 1'b0, s1 = 1'b0, f1 = 1'b0;
  logic        v3 = 1'b0, s3 = 1'b0, f3 = 1'b0;
  logic [31:0] i1 = '0, i3 = '0;

  logic       val1, rw1, as1, rdst1, br1, bt1, j1, mr1, mw1, m2r1, hz1, ill1;
  logic [2:0] alu1;
  logic [4:0] wr1;
  logic       val3, rw3, as3, rdst3, br3, bt3, j3, mr3, mw3, m2r3, hz3, ill3;
  logic [2:0] alu3;
  logic [4:0] wr3;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] LW8  = {6'h23, 5'd29, 5'd8, 16'd4};
  localparam logic [31:0] LW0  = {6'h23, 5'd29, 5'd0, 16'd4};
  localparam logic [31:0] ADD  = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] ADD0 = {6'h00, 5'd0, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] JMP  = {6'h02, 26'd100};
  localparam logic [31:0] ADDI = {6'h08, 5'd1, 5'd4, 16'd7};
  localparam logic [31:0] SW   = {6'h2B, 5'd1, 5'd5, 16'd0};

  pipe_id_decoder #(.LU_STALL_CYC(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .instr_valid_i(v1), .instr_i(i1), .stall_i(s1), .flush_i(f1),
    .valid_o(val1), .RegWrite_o(rw1), .ALU_op_o(alu1), .ALUSrc_o(as1), .RegDst_o(rdst1),
    .Branch_o(br1), .BranchType_o(bt1), .Jump_o(j1), .MemRead_o(mr1), .MemWrite_o(mw1),
    .MemtoReg_o(m2r1), .wr_reg_o(wr1), .hazard_stall_o(hz1), .illegal_o(ill1)
  );

  pipe_id_decoder #(.LU_STALL_CYC(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .instr_valid_i(v3), .instr_i(i3), .stall_i(s3), .flush_i(f3),
    .valid_o(val3), .RegWrite_o(rw3), .ALU_op_o(alu3), .ALUSrc_o(as3), .RegDst_o(rdst3),
    .Branch_o(br3), .BranchType_o(bt3), .Jump_o(j3), .MemRead_o(mr3), .MemWrite_o(mw3),
    .MemtoReg_o(m2r3), .wr_reg_o(wr3), .hazard_stall_o(hz3), .illegal_o(ill3)
  );

  always #5 clk = ~clk;

  wire [18:0] o1 = {val1, rw1, alu1, as1, rdst1, br1, bt1, j1, mr1, mw1, m2r1, wr1, ill1};
  wire [18:0] o3 = {val3, rw3, alu3, as3, rdst3, br3, bt3, j3, mr3, mw3, m2r3, wr3, ill3};

  // Hand-written decode table: {valid, RegWrite, ALU_op, ALUSrc, RegDst, Branch,
  // BranchType, Jump, MemRead, MemWrite, MemtoReg, wr_reg, illegal}.
  function automatic logic [18:0] exp_out(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rd);
    case (op)
      6'h00:   return {1'b1, 1'b1, 3'd2, 8'b0100_0000, rd, 1'b0};
      6'h08:   return {1'b1, 1'b1, 3'd3, 8'b1000_0000, rt, 1'b0};
      6'h0A:   return {1'b1, 1'b1, 3'd4, 8'b1000_0000, rt, 1'b0};
      6'h23:   return {1'b1, 1'b1, 3'd0, 8'b1000_0101, rt, 1'b0};
      6'h2B:   return {1'b1, 1'b0, 3'd0, 8'b1000_0010, rt, 1'b0};
      6'h04:   return {1'b1, 1'b0, 3'd1, 8'b0010_0000, rt, 1'b0};
      6'h05:   return {1'b1, 1'b0, 3'd1, 8'b0011_0000, rt, 1'b0};
      6'h02:   return {1'b1, 1'b0, 3'd0, 8'b0000_1000, rt, 1'b0};
      default: return {18'd0, 1'b1};
    endcase
  endfunction

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("reset_out1", o1, 19'd0);
    check("reset_hz1", {18'd0, hz1}, 19'd0);
    rst = 1'b1;
    tick();

    // Asynchronous reset in the middle of a load.
    v1 = 1'b1; i1 = LW8;
    tick();
    check("lw_issue", o1, exp_out(6'h23, 5'd8, 5'd0));
    #2 rst = 1'b0;
    #1 check("async_rst", o1, 19'd0);
    v1 = 1'b0;
    #1 rst = 1'b1;
    tick();
    check("post_rst_idle", o1, 19'd0);

    // Opcode sweep.
    for (int op = 0; op < 64; op++) begin
      i1 = {6'(op), 5'd1, 5'd2, 5'd3, 11'd0};
      v1 = 1'b1;
      tick();
      check($sformatf("sweep_%02h", op), o1, exp_out(6'(op), 5'd2, 5'd3));
      check("sweep_nox", {18'd0, $isunknown({o1, hz1})}, 19'd0);
    end
    v1 = 1'b0;
    tick();
    check("illegal_pulse_end", o1, 19'd0);

    // Load-use with one bubble.
    v1 = 1'b1; i1 = LW8;
    tick();
    i1 = ADD;
    #1 check("lu1_hz", {18'd0, hz1}, 19'd1);
    tick();
    check("lu1_bubble", o1, 19'd0);
    check("lu1_hz_clear", {18'd0, hz1}, 19'd0);
    tick();
    check("lu1_add", o1, exp_out(6'h00, 5'd10, 5'd9));

    // Load-use with three bubbles.
    v3 = 1'b1; i3 = LW8;
    tick();
    i3 = ADD;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("lu3_hz_%0d", k), {18'd0, hz3}, 19'd1);
      tick();
      check($sformatf("lu3_bubble_%0d", k), o3, 19'd0);
    end
    #1 check("lu3_hz_clear", {18'd0, hz3}, 19'd0);
    tick();
    check("lu3_add", o3, exp_out(6'h00, 5'd10, 5'd9));

    // Register 0 and jumps never hazard.
    i1 = LW0;
    tick();
    i1 = ADD0;
    #1 check("r0_nohz", {18'd0, hz1}, 19'd0);
    tick();
    check("r0_add", o1, exp_out(6'h00, 5'd10, 5'd9));
    i1 = LW8;
    tick();
    i1 = JMP;
    #1 check("j_nohz", {18'd0, hz1}, 19'd0);
    tick();
    check("j_issue", o1, exp_out(6'h02, 5'd0, 5'd0));

    // Stall then flush during the three-bubble sequence.
    i3 = LW8;
    tick();
    i3 = ADD;
    #1 check("fl_hz", {18'd0, hz3}, 19'd1);
    tick();
    check("fl_bubble1", o3, 19'd0);
    s3 = 1'b1;
    tick();
    check("fl_stall_out", o3, 19'd0);
    check("fl_stall_hz", {18'd0, hz3}, 19'd1);
    s3 = 1'b0; f3 = 1'b1;
    tick();
    f3 = 1'b0;
    #1 check("fl_out", o3, 19'd0);
    check("fl_hz_clear", {18'd0, hz3}, 19'd0);
    tick();
    check("fl_add", o3, exp_out(6'h00, 5'd10, 5'd9));

    // Stall mid-count must not consume bubbles.
    i3 = LW8;
    tick();
    i3 = ADD;
    tick();
    s3 = 1'b1;
    tick();
    tick();
    check("sc_hold_out", o3, 19'd0);
    s3 = 1'b0;
    #1 check("sc_hz_a", {18'd0, hz3}, 19'd1);
    tick();
    check("sc_bubble2", o3, 19'd0);
    check("sc_hz_b", {18'd0, hz3}, 19'd1);
    tick();
    check("sc_bubble3", o3, 19'd0);
    check("sc_hz_clear", {18'd0, hz3}, 19'd0);
    tick();
    check("sc_add", o3, exp_out(6'h00, 5'd10, 5'd9));

    // Downstream stall freezes the ID/EX slot.
    i1 = ADDI;
    tick();
    check("addi_issue", o1, exp_out(6'h08, 5'd4, 5'd0));
    s1 = 1'b1; i1 = SW;
    tick();
    check("stall_hold1", o1, exp_out(6'h08, 5'd4, 5'd0));
    tick();
    check("stall_hold2", o1, exp_out(6'h08, 5'd4, 5'd0));
    s1 = 1'b0;
    tick();
    check("sw_issue", o1, exp_out(6'h2B, 5'd5, 5'd0));

    // Flush kills a valid instruction, even with stall asserted.
    i1 = ADD; s1 = 1'b1; f1 = 1'b1;
    tick();
    check("flush_kill", o1, 19'd0);
    s1 = 1'b0; f1 = 1'b0; v1 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
